// File: rtl/conv_result_fifo.sv
// Convolution result FIFO: edge-triggered write/drain commands, streaming drain.
// Optional macro CONV_FIFO_PEAK_EN adds peak_count (highest occupancy since reset).
module conv_result_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              fifo_command,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_ready,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic                    rd_last,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    err,
  output logic                    busy
`ifdef CONV_FIFO_PEAK_EN
  ,
  output logic [$clog2(DEPTH):0]  peak_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b10;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_ILL  = 2'b11;

  state_e            state_q, state_d;
  logic [1:0]        cmd_q;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_q, err_d;
  logic              do_wr, do_pop;
  logic              cmd_new;
  logic              cmd_wr, cmd_rd, cmd_ill;
  logic              full_w, empty_w;

  logic [DATA_W-1:0] mem [DEPTH];

  // Command edge detect: only a change from last cycle's command acts
  always_comb begin
    cmd_new = (fifo_command != cmd_q);
    cmd_wr  = cmd_new && (fifo_command == CMD_WR);
    cmd_rd  = cmd_new && (fifo_command == CMD_RD);
    cmd_ill = cmd_new && (fifo_command == CMD_ILL);
    full_w  = (count_q == CW'(DEPTH));
    empty_w = (count_q == '0);
  end

  // State register and command history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_IDLE;
    end else begin
      state_q <= state_d;
      cmd_q   <= fifo_command;
    end
  end

  // Next-state logic plus the write/pop/error decisions it implies
  always_comb begin
    state_d = state_q;
    do_wr   = 1'b0;
    do_pop  = 1'b0;
    err_d   = err_q;
    if (cmd_ill) begin
      err_d = 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (cmd_wr) begin
          if (full_w) begin
            err_d = 1'b1;
          end else begin
            do_wr = 1'b1;
          end
        end
        if (cmd_rd && !empty_w) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cmd_wr) begin
          err_d = 1'b1;
        end
        if (rd_ready) begin
          do_pop = 1'b1;
          if (count_q == CW'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs: drain handshake and status flags
  always_comb begin
    rd_valid = (state_q == S_DRAIN);
    busy     = (state_q == S_DRAIN);
    rd_last  = (state_q == S_DRAIN) && (count_q == CW'(1));
    rd_data  = mem[rptr_q];
    count    = count_q;
    full     = full_w;
    empty    = empty_w;
    err      = err_q;
  end

  // Pointer and occupancy next-state; write and pop never coincide
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_wr) begin
      wptr_d  = wptr_q + AW'(1);
      count_d = count_q + CW'(1);
    end
    if (do_pop) begin
      rptr_d  = rptr_q + AW'(1);
      count_d = count_q - CW'(1);
    end
  end

  // Pointer, occupancy and sticky error registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr_q] <= wr_data;
    end
  end

`ifdef CONV_FIFO_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  // High-water mark follows count upward only
  always_comb begin
    peak_d = peak_q;
    if (count_d > peak_q) begin
      peak_d = count_d;
    end
  end

  // Peak register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_count = peak_q;
`endif

endmodule

// File: doc/conv_result_fifo.md
CONV_RESULT_FIFO -- requirements
Module: conv_result_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of one convolution result word.
REQ-002 SHALL have parameter DEPTH, default 256, number of storable results (power of two).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fifo_command  input  2  controller command: 00 idle, 10 write, 01 read/drain, 11 illegal.
REQ-006 SHALL have port wr_data  input  DATA_W  result word from the L4_ADD adder stage.
REQ-007 SHALL have port rd_ready  input  1  downstream sink accepts rd_data this cycle.
REQ-008 SHALL have port rd_data  output  DATA_W  head entry.
REQ-009 SHALL have port rd_valid  output  1  rd_data valid.
REQ-010 SHALL have port rd_last  output  1  rd_data is the final stored entry.
REQ-011 SHALL have port count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 SHALL have ports full, empty  output  1 each  occupancy == DEPTH / == 0.
REQ-013 SHALL have port err  output  1  sticky error flag.
REQ-014 SHALL have port busy  output  1  high while in DRAIN state.

Function
REQ-015 SHALL act on command edges only: a command is "new" when fifo_command differs from its value registered on the previous cycle; a held command causes no further action.
REQ-016 SHALL implement states IDLE and DRAIN; reset enters IDLE.
REQ-017 SHALL, in IDLE on new 10 with full low, write wr_data at the write pointer, advance it, and increment count on that edge.
REQ-018 SHALL, in IDLE on new 10 with full high, drop the word, leave count unchanged, and set err.
REQ-019 SHALL, in IDLE on new 01 with empty low, enter DRAIN next cycle; with empty high, stay in IDLE with no other effect.
REQ-020 SHALL, in DRAIN, drive rd_valid high and rd_data from the head entry combinationally, with zero latency from state entry.
REQ-021 SHALL pop one entry per cycle in which rd_valid and rd_ready are both high; rd_data SHALL hold stable while rd_ready is low.
REQ-022 SHALL drive rd_last high exactly when rd_valid is high and count == 1.
REQ-023 SHALL return to IDLE on the cycle after the rd_last transfer; busy SHALL fall on the same edge.
REQ-024 SHALL, in DRAIN, drop any new 10 and set err; any new 01 SHALL be ignored.
REQ-025 SHALL treat new 11 in any state as a no-op that sets err.
REQ-026 SHALL wrap read and write pointers modulo DEPTH without gaps.
REQ-027 SHALL hold rd_valid and rd_last low in IDLE.
REQ-028 SHALL clear err only by reset.

Reset
REQ-029 SHALL, on reset low and independent of clk, force: state IDLE, both pointers 0, count 0, empty 1, full 0, rd_valid 0, rd_last 0, busy 0, err 0, registered command 00.
REQ-030 SHALL, on reset asserted mid-DRAIN, discard all stored entries.
REQ-031 SHALL NOT reset storage contents.
REQ-032 SHALL act on the first new command arriving after reset release.

Configuration
REQ-033 SHALL, when macro CONV_FIFO_PEAK_EN is defined, add output peak_count (same width as count) holding the highest count reached since reset, reset value 0.
REQ-034 SHALL, when CONV_FIFO_PEAK_EN is undefined, omit peak_count and its register entirely, with all other behaviour identical.

Verification
REQ-035 SHALL cover: 3 write edges with wr_data 0x0011, 0x0022, 0x0033, then 01 with rd_ready=1 -> rd_data 0x0011, 0x0022, 0x0033 on consecutive cycles, rd_last on 0x0033, busy low one cycle later, count 0.
REQ-036 SHALL cover: 10 held for 5 cycles -> count == 1.
REQ-037 SHALL cover: 257 write edges -> count 256, full 1, err 1, 257th word absent on drain.
REQ-038 SHALL cover: drain with rd_ready toggling 1,0,0,1 -> second entry held stable for 3 cycles, and no entry is lost or duplicated.
REQ-039 SHALL cover: reset pulsed after 2 of 4 entries drained -> count 0, busy 0, rd_valid 0 immediately and without a clock edge.
REQ-040 SHALL cover: with CONV_FIFO_PEAK_EN defined, 10 writes, full drain, 3 writes -> peak_count 10, count 3.
